// File: rtl/hvsync_generator.sv
// VGA raster timing generator: horizontal/vertical beam counters with registered sync outputs
// and a combinational active-video decode. Default parameters give 640x480 at 60 Hz.
module hvsync_generator #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_BOTTOM    = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_TOP       = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE     = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACTIVE     = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;

    logic [9:0] w_hpos_next;
    logic [9:0] w_vpos_next;
    logic       w_h_wrap;
    logic       w_hsync_next;
    logic       w_vsync_next;

    // '>=' rather than '==' so an out-of-range count still wraps at the next wrap point.
    always_comb begin
        w_h_wrap    = (r_hpos >= H_LAST);
        w_hpos_next = r_hpos + 10'd1;
        w_vpos_next = r_vpos;
        if (w_h_wrap) begin
            w_hpos_next = '0;
            if (r_vpos >= V_LAST) begin
                w_vpos_next = '0;
            end else begin
                w_vpos_next = r_vpos + 10'd1;
            end
        end
    end

    // Syncs decode the next counter values so the flopped result aligns with hpos/vpos.
    always_comb begin
        w_hsync_next = ~SYNC_ACTIVE;
        w_vsync_next = ~SYNC_ACTIVE;
        if ((w_hpos_next >= H_SYNC_FIRST) && (w_hpos_next <= H_SYNC_LAST)) begin
            w_hsync_next = SYNC_ACTIVE;
        end
        if ((w_vpos_next >= V_SYNC_FIRST) && (w_vpos_next <= V_SYNC_LAST)) begin
            w_vsync_next = SYNC_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos  <= '0;
            r_vpos  <= '0;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_hpos  <= w_hpos_next;
            r_vpos  <= w_vpos_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = (r_hpos < H_ACTIVE) && (r_vpos < V_ACTIVE);

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench: full-size 640x480 instance for reset/line/async-reset checks, and a shrunken
// instance with active-high syncs for frame-level vertical timing within a short run.
module tb_hvsync_generator;

    logic       clk;
    logic       rst_n_a;
    logic       rst_n_b;

    logic       hsync_a, vsync_a, display_on_a;
    logic [9:0] hpos_a, vpos_a;
    logic       hsync_b, vsync_b, display_on_b;
    logic [9:0] hpos_b, vpos_b;

    int n_cmp = 0;
    int n_err = 0;

    hvsync_generator u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n_a),
        .hsync      (hsync_a),
        .vsync      (vsync_a),
        .display_on (display_on_a),
        .hpos       (hpos_a),
        .vpos       (vpos_a)
    );

    // Small raster: H total 25 (sync 18..21), V total 17 (sync lines 12..13), frame 425 clocks.
    hvsync_generator #(
        .H_DISPLAY   (16),
        .H_FRONT     (2),
        .H_SYNC      (4),
        .H_BACK      (3),
        .V_DISPLAY   (10),
        .V_BOTTOM    (2),
        .V_SYNC      (2),
        .V_TOP       (3),
        .SYNC_ACTIVE (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .hsync      (hsync_b),
        .vsync      (vsync_b),
        .display_on (display_on_b),
        .hpos       (hpos_b),
        .vpos       (vpos_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low;
        int vs_act;
        int hs_act;
        int de_cnt;
        int pulses;
        logic prev_vs;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;

        // ---------------- full-size instance ----------------
        repeat (5) tick();
        check_eq("a_rst_hpos", 32'(hpos_a), 0);
        check_eq("a_rst_vpos", 32'(vpos_a), 0);
        check_eq("a_rst_hsync", 32'(hsync_a), 1);
        check_eq("a_rst_vsync", 32'(vsync_a), 1);
        check_eq("a_rst_de", 32'(display_on_a), 1);

        rst_n_a = 1'b1;
        hs_low  = 0;
        for (int e = 1; e <= 800; e++) begin
            tick();
            if (hsync_a == 1'b0) hs_low++;
            case (e)
                1:   check_eq("a_first_hpos", 32'(hpos_a), 1);
                639: check_eq("a_de_639", 32'(display_on_a), 1);
                640: check_eq("a_de_640", 32'(display_on_a), 0);
                655: check_eq("a_hs_655", 32'(hsync_a), 1);
                656: begin
                    check_eq("a_hpos_656", 32'(hpos_a), 656);
                    check_eq("a_hs_656", 32'(hsync_a), 0);
                end
                751: check_eq("a_hs_751", 32'(hsync_a), 0);
                752: check_eq("a_hs_752", 32'(hsync_a), 1);
                799: check_eq("a_vpos_799", 32'(vpos_a), 0);
                800: begin
                    check_eq("a_line_hpos", 32'(hpos_a), 0);
                    check_eq("a_line_vpos", 32'(vpos_a), 1);
                    check_eq("a_line_vsync", 32'(vsync_a), 1);
                end
                default: ;
            endcase
        end
        check_eq("a_hs_low_cnt", 32'(hs_low), 96);

        // Async reset between edges at (300,1).
        repeat (300) tick();
        check_eq("a_mid_hpos", 32'(hpos_a), 300);
        check_eq("a_mid_vpos", 32'(vpos_a), 1);
        #1 rst_n_a = 1'b0;
        #1;
        check_eq("a_async_hpos", 32'(hpos_a), 0);
        check_eq("a_async_vpos", 32'(vpos_a), 0);
        check_eq("a_async_hsync", 32'(hsync_a), 1);
        check_eq("a_async_de", 32'(display_on_a), 1);
        repeat (2) tick();
        rst_n_a = 1'b1;
        tick();
        check_eq("a_restart_hpos", 32'(hpos_a), 1);
        check_eq("a_restart_vpos", 32'(vpos_a), 0);

        // ---------------- small instance, active-high syncs ----------------
        tick();
        check_eq("b_rst_hsync", 32'(hsync_b), 0);
        check_eq("b_rst_vsync", 32'(vsync_b), 0);
        check_eq("b_rst_de", 32'(display_on_b), 1);
        rst_n_b = 1'b1;
        vs_act  = 0;
        hs_act  = 0;
        de_cnt  = 0;
        pulses  = 0;
        prev_vs = 1'b0;
        for (int e = 1; e <= 425; e++) begin
            tick();
            if (vsync_b) vs_act++;
            if (hsync_b) hs_act++;
            if (display_on_b) de_cnt++;
            if (vsync_b && !prev_vs) pulses++;
            prev_vs = vsync_b;
            case (e)
                15:  check_eq("b_de_15_0", 32'(display_on_b), 1);
                16:  check_eq("b_de_16_0", 32'(display_on_b), 0);
                250: check_eq("b_de_0_10", 32'(display_on_b), 0);
                299: check_eq("b_vs_24_11", 32'(vsync_b), 0);
                300: begin
                    check_eq("b_vpos_300", 32'(vpos_b), 12);
                    check_eq("b_vs_0_12", 32'(vsync_b), 1);
                end
                349: check_eq("b_vs_24_13", 32'(vsync_b), 1);
                350: check_eq("b_vs_0_14", 32'(vsync_b), 0);
                424: begin
                    check_eq("b_last_hpos", 32'(hpos_b), 24);
                    check_eq("b_last_vpos", 32'(vpos_b), 16);
                    check_eq("b_last_de", 32'(display_on_b), 0);
                end
                425: begin
                    check_eq("b_wrap_hpos", 32'(hpos_b), 0);
                    check_eq("b_wrap_vpos", 32'(vpos_b), 0);
                    check_eq("b_wrap_de", 32'(display_on_b), 1);
                end
                default: ;
            endcase
        end
        check_eq("b_vs_act_cnt", 32'(vs_act), 50);
        check_eq("b_hs_act_cnt", 32'(hs_act), 68);
        check_eq("b_de_cnt", 32'(de_cnt), 160);
        check_eq("b_vs_pulses", 32'(pulses), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
